cdb_result_queue: RTL and testbench
===================================

Name: cdb_result_queue

Overview:
Per-functional-unit result queue that sits directly upstream of the CDB arbiter. It buffers completed results (ROB/RS tag plus data) from one functional unit, such as ld/st or an ALU. It raises that unit's request bit into the arbiter's cdb_req vector and pops the head entry when the arbiter's matching fu_sel bit grants it. One instance is built per functional unit; the three cdb_req_o outputs are concatenated as {ldst, alu1, alu0}.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
TAG_W, 5, width of the destination tag
DATA_W, 32, width of the result value

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous active-low reset
stall_i  in  1  pipeline stall, the same signal the arbiter receives; blocks pops only
flush_i  in  1  synchronous flush (mispredict); empties the queue
fu_valid_i  in  1  functional unit presents a completed result
fu_tag_i  in  TAG_W  tag of the result
fu_data_i  in  DATA_W  result value
fu_ready_o  out  1  queue can accept a push this cycle
cdb_req_o  out  1  request to the arbiter (this unit's bit of cdb_req)
cdb_grant_i  in  1  this unit's bit of the arbiter's fu_sel
cdb_valid_o  out  1  head entry is being broadcast on the CDB this cycle
cdb_tag_o  out  TAG_W  head tag
cdb_data_o  out  DATA_W  head data
overflow_o  out  1  sticky error flag: a push was attempted while the queue was full

Behaviour:
- State: circular buffer of DEPTH entries; rd_ptr and wr_ptr of log2(DEPTH) bits wrap modulo DEPTH; count of log2(DEPTH)+1 bits.
- Reset (rst=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0, overflow_o=0. Outputs immediately become fu_ready_o=1, cdb_req_o=0, cdb_valid_o=0, cdb_tag_o=0, cdb_data_o=0. Storage array is not reset.
- Combinational outputs:
  - fu_ready_o = (count != DEPTH).
  - cdb_req_o = (count != 0).
  - cdb_tag_o / cdb_data_o = head entry when count != 0, else 0. The queue is first-word-fall-through, so zero cycles pass from write to head visibility once the entry is the oldest.
  - cdb_valid_o = cdb_req_o & cdb_grant_i & !stall_i.
- Grant contract: the arbiter returns cdb_grant_i combinationally in the same cycle as cdb_req_o.
- push = fu_valid_i & fu_ready_o. On the clock edge: write at wr_ptr, increment wr_ptr.
- pop = cdb_valid_o. On the clock edge: increment rd_ptr.
- Simultaneous push and pop: both occur and count is unchanged. This is legal at any non-zero count, including full? No: when full, fu_ready_o=0 and the push is refused. There is no same-cycle bypass; a full queue accepts the next push one cycle after a pop.
- Empty queue: cdb_grant_i is ignored, and no pop or pointer movement occurs. A push into an empty queue raises cdb_req_o in the next cycle.
- Stall: while stall_i=1, no pop occurs and head and pointers hold. Pushes proceed, so the queue may fill during a stall.
- Flush: flush_i=1 on a clock edge sets rd_ptr=wr_ptr=0 and count=0. It takes priority over a same-cycle push and pop; both are discarded. overflow_o is unaffected.
- Overflow: fu_valid_i=1 while fu_ready_o=0 sets overflow_o=1 on the edge. overflow_o holds until rst. The data is dropped and state is unchanged.
- Ordering: strict FIFO; results leave in arrival order.
- Reset mid-operation: all entries are lost immediately and the outputs return to their reset values asynchronously.
- Assertions:
  - Bench assertion: cdb_grant_i never goes high while cdb_req_o=0, when checked against the arbiter.
  - Bench assertion: count never exceeds DEPTH.

Test Plan:
- Reset and single pass: deassert rst, push tag=3/data=0xDEAD_BEEF with grant held 1 -> cdb_req_o=1 the next cycle with cdb_tag_o=3 and cdb_data_o=0xDEADBEEF; cdb_valid_o=1 for exactly one cycle; then empty with cdb_req_o=0.
- Fill and back-pressure (DEPTH=4), grant=0:
  - Push tags 1..4 -> fu_ready_o=0 after the 4th.
  - A 5th push with tag=9 -> overflow_o=1 and is dropped.
  - Then grant=1 -> outputs are tags 1,2,3,4 on consecutive cycles, and tag 9 never appears.
- Simultaneous push/pop: count=2 (tags 5,6), push tag 7 with grant=1 -> tag 5 pops, count stays 2, head becomes 6, and order 6,7 is preserved.
- Stall:
  - count=1 (tag 2), grant=1, stall_i=1 for 3 cycles -> cdb_valid_o=0 and head stays tag 2.
  - Meanwhile push tags 3,4 -> count=3.
  - Release stall -> tags 2,3,4 are broadcast in order.
- Flush priority: count=3, assert flush_i with push of tag 8 and grant=1 -> next cycle count=0, cdb_req_o=0, fu_ready_o=1, and tag 8 is absent.
- Asynchronous reset mid-stream: count=2 with overflow_o=1, drop rst between clock edges -> cdb_req_o=0, cdb_tag_o=0, and overflow_o=0 immediately, before the next edge.

Source files
------------

// File: rtl/cdb_result_queue.sv
// Per-functional-unit result FIFO feeding the CDB arbiter.
// It is first-word-fall-through: the head is driven combinationally and pops when the arbiter grants it.
module cdb_result_queue #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              fu_valid_i,
  input  logic [TAG_W-1:0]  fu_tag_i,
  input  logic [DATA_W-1:0] fu_data_i,
  output logic              fu_ready_o,
  output logic              cdb_req_o,
  input  logic              cdb_grant_i,
  output logic              cdb_valid_o,
  output logic [TAG_W-1:0]  cdb_tag_o,
  output logic [DATA_W-1:0] cdb_data_o,
  output logic              overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [TAG_W-1:0]  r_tag_mem  [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic w_ready;
  logic w_req;
  logic w_push;
  logic w_pop;

  assign w_ready = (r_count != FULL_CNT);
  assign w_req   = (r_count != '0);
  assign w_push  = fu_valid_i & w_ready;
  assign w_pop   = w_req & cdb_grant_i & ~stall_i;

  assign fu_ready_o  = w_ready;
  assign cdb_req_o   = w_req;
  assign cdb_valid_o = w_pop;
  assign cdb_tag_o   = w_req ? r_tag_mem[r_rd_ptr]  : '0;
  assign cdb_data_o  = w_req ? r_data_mem[r_rd_ptr] : '0;
  assign overflow_o  = r_overflow;

  // Storage is deliberately left unreset; only pointer and count state is reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr]  <= fu_tag_i;
      r_data_mem[r_wr_ptr] <= fu_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky until reset; a flush leaves it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (fu_valid_i && !w_ready) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_result_queue.sv
// Self-checking bench for cdb_result_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_cdb_result_queue;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int OUT_W  = 3 + 1 + TAG_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stallIn = 1'b0;
  logic              flushIn = 1'b0;
  logic              fuValid = 1'b0;
  logic [TAG_W-1:0]  fuTag = '0;
  logic [DATA_W-1:0] fuData = '0;
  logic              grantEn = 1'b0;
  logic              fu_ready_o;
  logic              cdb_req_o;
  logic              cdb_grant_i;
  logic              cdb_valid_o;
  logic [TAG_W-1:0]  cdb_tag_o;
  logic [DATA_W-1:0] cdb_data_o;
  logic              overflow_o;

  int checks = 0;
  int failures = 0;

  logic [TAG_W+DATA_W-1:0] mq[$];
  bit mOvf = 1'b0;

  // The arbiter only grants a unit that is requesting, in the same cycle.
  assign cdb_grant_i = grantEn & cdb_req_o;

  cdb_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .stall_i(stallIn), .flush_i(flushIn),
    .fu_valid_i(fuValid), .fu_tag_i(fuTag), .fu_data_i(fuData),
    .fu_ready_o(fu_ready_o), .cdb_req_o(cdb_req_o), .cdb_grant_i(cdb_grant_i),
    .cdb_valid_o(cdb_valid_o), .cdb_tag_o(cdb_tag_o), .cdb_data_o(cdb_data_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      assert (!(cdb_grant_i && !cdb_req_o));
      assert (int'(dut.r_count) <= DEPTH);
    end
  end

  // Expected {overflow, ready, req, valid, tag, data} from the model's current contents.
  function automatic logic [OUT_W-1:0] expOut();
    logic req;
    logic [TAG_W+DATA_W-1:0] head;
    req  = (mq.size() != 0);
    head = req ? mq[0] : '0;
    return {mOvf, (mq.size() != DEPTH), req, (req && grantEn && !stallIn), head};
  endfunction

  task automatic tick();
    bit ready;
    bit pop;
    ready = (mq.size() != DEPTH);
    pop   = (mq.size() != 0) && grantEn && !stallIn;
    @(posedge clk);
    if (fuValid && !ready) mOvf = 1'b1;
    if (flushIn) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (fuValid && ready) mq.push_back({fuTag, fuData});
    end
    #1;
  endtask

  task automatic idleInputs();
    stallIn = 1'b0; flushIn = 1'b0; fuValid = 1'b0; grantEn = 1'b0;
    fuTag = '0; fuData = '0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b0;
    idleInputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    mOvf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pushOne(input logic [TAG_W-1:0] tag);
    fuValid = 1'b1; fuTag = tag; fuData = $urandom;
    tick();
    fuValid = 1'b0;
  endtask

  task automatic test_reset();
    resetDut();
    #2;
    checks++;
    if ({overflow_o, fu_ready_o, cdb_req_o, cdb_valid_o} !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 0100", {overflow_o, fu_ready_o, cdb_req_o, cdb_valid_o});
    end
    checks++;
    if (cdb_tag_o !== '0 || cdb_data_o !== '0) begin
      failures++;
      $display("[TB] FAIL reset_head: got %0d/%h expected 0/0", cdb_tag_o, cdb_data_o);
    end
  endtask

  task automatic test_single_pass();
    resetDut();
    fuValid = 1'b1; fuTag = 5'd3; fuData = 32'hDEAD_BEEF; grantEn = 1'b1;
    #2;
    checks++;
    if (cdb_req_o !== 1'b0) begin
      failures++; $display("[TB] FAIL single_req_before: got %b expected 0", cdb_req_o);
    end
    tick();
    fuValid = 1'b0;
    #2;
    checks++;
    if ({cdb_req_o, cdb_valid_o, cdb_tag_o, cdb_data_o} !== {1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF}) begin
      failures++;
      $display("[TB] FAIL single_head: got req=%b valid=%b tag=%0d data=%h expected 1 1 3 deadbeef",
               cdb_req_o, cdb_valid_o, cdb_tag_o, cdb_data_o);
    end
    tick();
    #2;
    checks++;
    if ({cdb_req_o, cdb_valid_o} !== 2'b00) begin
      failures++; $display("[TB] FAIL single_empty: got %b expected 00", {cdb_req_o, cdb_valid_o});
    end
  endtask

  task automatic test_fill_overflow();
    resetDut();
    for (int i = 1; i <= 4; i++) pushOne(TAG_W'(i));
    #2;
    checks++;
    if (fu_ready_o !== 1'b0) begin
      failures++; $display("[TB] FAIL fill_ready: got %b expected 0", fu_ready_o);
    end
    pushOne(5'd9);
    #2;
    checks++;
    if (overflow_o !== 1'b1) begin
      failures++; $display("[TB] FAIL fill_overflow: got %b expected 1", overflow_o);
    end
    grantEn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #2;
      checks++;
      if (cdb_valid_o !== 1'b1 || cdb_tag_o !== TAG_W'(i)) begin
        failures++;
        $display("[TB] FAIL fill_order: got valid=%b tag=%0d expected 1 %0d", cdb_valid_o, cdb_tag_o, i);
      end
      tick();
    end
    #2;
    checks++;
    if (cdb_req_o !== 1'b0) begin
      failures++; $display("[TB] FAIL fill_drained: got req=%b tag=%0d expected req 0", cdb_req_o, cdb_tag_o);
    end
    grantEn = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [OUT_W-1:0] exp;
    resetDut();
    pushOne(5'd5);
    pushOne(5'd6);
    fuValid = 1'b1; fuTag = 5'd7; fuData = $urandom; grantEn = 1'b1;
    #2;
    checks++;
    if (cdb_valid_o !== 1'b1 || cdb_tag_o !== 5'd5) begin
      failures++; $display("[TB] FAIL simul_pop: got valid=%b tag=%0d expected 1 5", cdb_valid_o, cdb_tag_o);
    end
    tick();
    fuValid = 1'b0; grantEn = 1'b0;
    #2;
    exp = expOut();
    checks++;
    if (mq.size() != 2 || cdb_tag_o !== 5'd6 || {overflow_o, fu_ready_o, cdb_req_o, cdb_valid_o, cdb_tag_o, cdb_data_o} !== exp) begin
      failures++;
      $display("[TB] FAIL simul_head: got tag=%0d data=%h expected tag 6 data=%h", cdb_tag_o, cdb_data_o, exp[DATA_W-1:0]);
    end
    grantEn = 1'b1;
    for (int i = 6; i <= 7; i++) begin
      #2;
      checks++;
      if (cdb_valid_o !== 1'b1 || cdb_tag_o !== TAG_W'(i)) begin
        failures++; $display("[TB] FAIL simul_order: got tag=%0d expected %0d", cdb_tag_o, i);
      end
      tick();
    end
    grantEn = 1'b0;
  endtask

  task automatic test_stall();
    resetDut();
    pushOne(5'd2);
    grantEn = 1'b1; stallIn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      fuValid = (c < 2); fuTag = TAG_W'(3 + c); fuData = $urandom;
      #2;
      checks++;
      if (cdb_valid_o !== 1'b0 || cdb_tag_o !== 5'd2) begin
        failures++; $display("[TB] FAIL stall_hold: got valid=%b tag=%0d expected 0 2", cdb_valid_o, cdb_tag_o);
      end
      tick();
    end
    fuValid = 1'b0; stallIn = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      #2;
      checks++;
      if (cdb_valid_o !== 1'b1 || cdb_tag_o !== TAG_W'(i)) begin
        failures++; $display("[TB] FAIL stall_order: got valid=%b tag=%0d expected 1 %0d", cdb_valid_o, cdb_tag_o, i);
      end
      tick();
    end
    grantEn = 1'b0;
  endtask

  task automatic test_flush();
    resetDut();
    for (int i = 1; i <= 3; i++) pushOne(TAG_W'(i));
    flushIn = 1'b1; fuValid = 1'b1; fuTag = 5'd8; fuData = $urandom; grantEn = 1'b1;
    tick();
    flushIn = 1'b0; fuValid = 1'b0;
    #2;
    checks++;
    if ({cdb_req_o, fu_ready_o, cdb_valid_o} !== 3'b010 || cdb_tag_o !== '0) begin
      failures++;
      $display("[TB] FAIL flush_empty: got req=%b ready=%b valid=%b tag=%0d expected 0 1 0 0",
               cdb_req_o, fu_ready_o, cdb_valid_o, cdb_tag_o);
    end
    tick();
    #2;
    checks++;
    if (cdb_req_o !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_no_tag8: got req=%b tag=%0d expected req 0", cdb_req_o, cdb_tag_o);
    end
    grantEn = 1'b0;
  endtask

  task automatic test_async_reset();
    resetDut();
    for (int i = 1; i <= 5; i++) pushOne(TAG_W'(i));
    grantEn = 1'b1;
    tick();
    tick();
    grantEn = 1'b0;
    #2;
    checks++;
    if ({overflow_o, cdb_req_o, cdb_tag_o} !== {1'b1, 1'b1, 5'd3}) begin
      failures++;
      $display("[TB] FAIL areset_setup: got ovf=%b req=%b tag=%0d expected 1 1 3", overflow_o, cdb_req_o, cdb_tag_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({overflow_o, cdb_req_o, fu_ready_o, cdb_valid_o, cdb_tag_o, cdb_data_o} !== {4'b0010, 5'd0, 32'd0}) begin
      failures++;
      $display("[TB] FAIL areset_immediate: got ovf=%b req=%b ready=%b tag=%0d data=%h expected 0 0 1 0 0",
               overflow_o, cdb_req_o, fu_ready_o, cdb_tag_o, cdb_data_o);
    end
    mq.delete();
    mOvf = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [OUT_W-1:0] exp;
    logic [OUT_W-1:0] got;
    resetDut();
    for (int c = 0; c < 400; c++) begin
      fuValid = ($urandom_range(0, 9) < 6);
      fuTag   = TAG_W'($urandom_range(0, 31));
      fuData  = $urandom;
      grantEn = $urandom_range(0, 1) == 1;
      stallIn = ($urandom_range(0, 3) == 0);
      flushIn = ($urandom_range(0, 31) == 0);
      #2;
      exp = expOut();
      got = {overflow_o, fu_ready_o, cdb_req_o, cdb_valid_o, cdb_tag_o, cdb_data_o};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL random_cycle%0d: got %h expected %h", c, got, exp);
      end
      tick();
    end
    idleInputs();
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_fill_overflow();
    test_simultaneous();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
